// File: rtl/chacha_pkg.sv
// rtl/chacha_pkg.sv - shared types, rotation constants and helpers for the inverse ChaCha quarter round
package chacha_pkg;

    typedef logic [31:0] word_t;

    // Rotation amounts of the inverse half-steps, in the order they are undone
    localparam logic [4:0] ROT0 = 5'd7;
    localparam logic [4:0] ROT1 = 5'd8;
    localparam logic [4:0] ROT2 = 5'd12;
    localparam logic [4:0] ROT3 = 5'd16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // 32-bit rotate right; a zero rotation yields x because x << 32 is zero
    function automatic word_t ror32(input word_t x, input logic [4:0] r);
        return (x >> r) | (x << (6'd32 - {1'b0, r}));
    endfunction

endpackage

// File: rtl/chacha_inv_step.sv
// rtl/chacha_inv_step.sv - one combinational inverse ARX half-step
module chacha_inv_step
    import chacha_pkg::*;
(
    input  logic [31:0] x,
    input  logic [31:0] y,
    input  logic [31:0] z,
    input  logic [4:0]  rot,
    output logic [31:0] x_nxt,
    output logic [31:0] y_nxt
);

    // x is un-rotated and un-XORed with y; y has z subtracted back out
    always_comb begin
        x_nxt = ror32(x, rot) ^ y;
        y_nxt = y - z;
    end

endmodule

// File: rtl/chacha_inv_qr_iter.sv
// rtl/chacha_inv_qr_iter.sv - iterative inverse ChaCha quarter round, one half-step per clock
module chacha_inv_qr_iter
    import chacha_pkg::*;
#(
    parameter int N_QR = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a_in,
    input  logic [31:0] b_in,
    input  logic [31:0] c_in,
    input  logic [31:0] d_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] a_out,
    output logic [31:0] b_out,
    output logic [31:0] c_out,
    output logic [31:0] d_out
);

    localparam int QW = (N_QR > 1) ? $clog2(N_QR) : 1;
    localparam logic [QW-1:0] QR_LAST = QW'(N_QR - 1);

    state_t          state_q, state_d;
    logic [1:0]      step_q, step_d;
    logic [QW-1:0]   qr_cnt_q, qr_cnt_d;
    word_t           w_a_q, w_a_d;
    word_t           w_b_q, w_b_d;
    word_t           w_c_q, w_c_d;
    word_t           w_d_q, w_d_d;

    logic            odd_step;
    word_t           st_x, st_y, st_z;
    word_t           st_x_nxt, st_y_nxt;
    logic [4:0]      st_rot;

    // Even steps rework (b,c) against d; odd steps rework (d,a) against b
    always_comb begin
        odd_step = step_q[0];
        st_x     = odd_step ? w_d_q : w_b_q;
        st_y     = odd_step ? w_a_q : w_c_q;
        st_z     = odd_step ? w_b_q : w_d_q;
        case (step_q)
            2'd0:    st_rot = ROT0;
            2'd1:    st_rot = ROT1;
            2'd2:    st_rot = ROT2;
            default: st_rot = ROT3;
        endcase
    end

    chacha_inv_step u_step (
        .x     (st_x),
        .y     (st_y),
        .z     (st_z),
        .rot   (st_rot),
        .x_nxt (st_x_nxt),
        .y_nxt (st_y_nxt)
    );

    // Next-state logic: load on accept, one half-step per cycle in RUN, hold in DONE
    always_comb begin
        state_d  = state_q;
        step_d   = step_q;
        qr_cnt_d = qr_cnt_q;
        w_a_d    = w_a_q;
        w_b_d    = w_b_q;
        w_c_d    = w_c_q;
        w_d_d    = w_d_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    w_a_d    = a_in;
                    w_b_d    = b_in;
                    w_c_d    = c_in;
                    w_d_d    = d_in;
                    step_d   = 2'd0;
                    qr_cnt_d = '0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                if (odd_step) begin
                    w_d_d = st_x_nxt;
                    w_a_d = st_y_nxt;
                end else begin
                    w_b_d = st_x_nxt;
                    w_c_d = st_y_nxt;
                end
                step_d = step_q + 2'd1;
                if (step_q == 2'd3) begin
                    if (qr_cnt_q == QR_LAST) begin
                        state_d = DONE;
                    end else begin
                        qr_cnt_d = qr_cnt_q + 1'b1;
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and working registers; reset discards any in-flight result
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= IDLE;
            step_q   <= 2'd0;
            qr_cnt_q <= '0;
            w_a_q    <= '0;
            w_b_q    <= '0;
            w_c_q    <= '0;
            w_d_q    <= '0;
        end else begin
            state_q  <= state_d;
            step_q   <= step_d;
            qr_cnt_q <= qr_cnt_d;
            w_a_q    <= w_a_d;
            w_b_q    <= w_b_d;
            w_c_q    <= w_c_d;
            w_d_q    <= w_d_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign a_out     = w_a_q;
    assign b_out     = w_b_q;
    assign c_out     = w_c_q;
    assign d_out     = w_d_q;

endmodule

// File: tb/tb_chacha_inv_qr_iter.sv
// tb/tb_chacha_inv_qr_iter.sv - scoreboard bench for the inverse ChaCha quarter round
module tb_chacha_inv_qr_iter;

    localparam logic [127:0] RFC_IN  = 128'hea2a92f4_cb1cf8ce_4581472e_5881c4bb;
    localparam logic [127:0] RFC_OUT = 128'h11111111_01020304_9b8d6f43_01234567;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        in_valid, out_ready, in_ready, out_valid;
    logic [31:0] a_in, b_in, c_in, d_in, a_out, b_out, c_out, d_out;
    logic        in_valid_2, out_ready_2, in_ready_2, out_valid_2;
    logic [31:0] a_in_2, b_in_2, c_in_2, d_in_2, a_out_2, b_out_2, c_out_2, d_out_2;

    int total = 0;
    int bad   = 0;
    logic [127:0] q1[$];
    logic [127:0] q2[$];
    bit rand_ready = 1'b0;

    chacha_inv_qr_iter #(.N_QR(1)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .a_in(a_in), .b_in(b_in), .c_in(c_in), .d_in(d_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .a_out(a_out), .b_out(b_out), .c_out(c_out), .d_out(d_out)
    );

    chacha_inv_qr_iter #(.N_QR(2)) dut2 (
        .clk(clk), .reset(reset),
        .in_valid(in_valid_2), .in_ready(in_ready_2),
        .a_in(a_in_2), .b_in(b_in_2), .c_in(c_in_2), .d_in(d_in_2),
        .out_valid(out_valid_2), .out_ready(out_ready_2),
        .a_out(a_out_2), .b_out(b_out_2), .c_out(c_out_2), .d_out(d_out_2)
    );

    function automatic logic [31:0] rol(input logic [31:0] x, input int n);
        return (x << n) | (x >> (32 - n));
    endfunction

    // Forward ChaCha quarter round as written in RFC 7539
    function automatic logic [127:0] qr_fwd(input logic [127:0] v);
        logic [31:0] a, b, c, d;
        {a, b, c, d} = v;
        a = a + b; d = rol(d ^ a, 16);
        c = c + d; b = rol(b ^ c, 12);
        a = a + b; d = rol(d ^ a, 8);
        c = c + d; b = rol(b ^ c, 7);
        return {a, b, c, d};
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h expected=%h", name, act, exp);
        end
    endtask

    // Monitors: every output handshake pops the oldest expectation
    always @(negedge clk) begin
        if (reset && out_valid && out_ready) begin
            if (q1.size() == 0) begin
                total++; bad++;
                $display("FAIL out1_unexpected got=%h expected=none", {a_out, b_out, c_out, d_out});
            end else begin
                check("out1", {a_out, b_out, c_out, d_out}, q1.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (reset && out_valid_2 && out_ready_2) begin
            if (q2.size() == 0) begin
                total++; bad++;
                $display("FAIL out2_unexpected got=%h expected=none", {a_out_2, b_out_2, c_out_2, d_out_2});
            end else begin
                check("out2", {a_out_2, b_out_2, c_out_2, d_out_2}, q2.pop_front());
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk); #1;
            if (rand_ready) out_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    // Called at #1 after a posedge; returns at #1 after the accepting edge
    task automatic send1(input logic [127:0] v, input logic [127:0] exp);
        int n;
        bit acc;
        {a_in, b_in, c_in, d_in} = v;
        in_valid = 1'b1;
        q1.push_back(exp);
        n = 0; acc = 1'b0;
        while (!acc && n < 200) begin
            @(negedge clk); acc = in_ready;
            @(posedge clk); #1; n++;
        end
        in_valid = 1'b0;
        if (!acc) begin
            total++; bad++;
            $display("FAIL send1_timeout got=no_accept expected=accept");
            void'(q1.pop_back());
        end
    endtask

    task automatic drain1();
        int n;
        n = 0;
        while (q1.size() != 0 && n < 1000) begin
            @(posedge clk); #1; n++;
        end
        if (q1.size() != 0) begin
            total++; bad++;
            $display("FAIL drain1_timeout got=%0d expected=0", q1.size());
        end
    endtask

    task automatic wait_valid1(output int lat, output bit ir_seen);
        lat = 0; ir_seen = 1'b0;
        while (!out_valid && lat < 50) begin
            if (in_ready) ir_seen = 1'b1;
            @(posedge clk); #1; lat++;
        end
        if (in_ready) ir_seen = 1'b1;
    endtask

    initial begin
        int lat;
        bit ir_seen, stable, acc;
        logic [127:0] v, snap;
        int n;

        reset = 1'b0;
        in_valid = 1'b0; out_ready = 1'b0;
        {a_in, b_in, c_in, d_in} = '0;
        in_valid_2 = 1'b0; out_ready_2 = 1'b0;
        {a_in_2, b_in_2, c_in_2, d_in_2} = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_outputs", {a_out, b_out, c_out, d_out}, 0);
        check("rst_out_valid_2", out_valid_2, 0);
        reset = 1'b1;
        @(posedge clk); #1;

        // RFC 7539 vector, latency 4
        send1(RFC_IN, RFC_OUT);
        wait_valid1(lat, ir_seen);
        check("rfc_latency", lat, 4);
        out_ready = 1'b1;
        drain1();
        out_ready = 1'b0;

        // All-zero input, in_ready low through RUN and DONE
        send1('0, '0);
        wait_valid1(lat, ir_seen);
        check("zero_latency", lat, 4);
        check("zero_in_ready_low", ir_seen, 0);
        out_ready = 1'b1;
        drain1();
        out_ready = 1'b0;

        // Back-pressure: DONE held 10 cycles, a second input ignored
        v = rnd128();
        send1(qr_fwd(v), v);
        wait_valid1(lat, ir_seen);
        check("bp_latency", lat, 4);
        snap = {a_out, b_out, c_out, d_out};
        stable = 1'b1;
        {a_in, b_in, c_in, d_in} = rnd128();
        in_valid = 1'b1;
        repeat (10) begin
            @(posedge clk); #1;
            if (!out_valid || in_ready || {a_out, b_out, c_out, d_out} !== snap) stable = 1'b0;
        end
        in_valid = 1'b0;
        check("bp_stable", stable, 1);
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_in_ready_after", in_ready, 1);
        check("bp_out_valid_low", out_valid, 0);
        out_ready = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        check("bp_no_ghost", out_valid, 0);
        check("bp_queue_empty", q1.size(), 0);

        // Reset during step2 discards the operation
        send1(RFC_IN, RFC_OUT);
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        q1.delete();
        check("midrst_in_ready", in_ready, 1);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_outputs", {a_out, b_out, c_out, d_out}, 0);
        out_ready = 1'b1;
        send1(RFC_IN, RFC_OUT);
        drain1();
        out_ready = 1'b0;

        // N_QR=2: two forward rounds undone in 8 cycles
        for (int k = 0; k < 3; k++) begin
            v = rnd128();
            {a_in_2, b_in_2, c_in_2, d_in_2} = qr_fwd(qr_fwd(v));
            in_valid_2 = 1'b1;
            q2.push_back(v);
            n = 0; acc = 1'b0;
            while (!acc && n < 50) begin
                @(negedge clk); acc = in_ready_2;
                @(posedge clk); #1; n++;
            end
            in_valid_2 = 1'b0;
            check("nqr2_accept", acc, 1);
            lat = 0;
            while (!out_valid_2 && lat < 50) begin
                @(posedge clk); #1; lat++;
            end
            check("nqr2_latency", lat, 8);
            out_ready_2 = 1'b1;
            n = 0;
            while (q2.size() != 0 && n < 50) begin
                @(posedge clk); #1; n++;
            end
            check("nqr2_drained", q2.size(), 0);
            out_ready_2 = 1'b0;
        end

        // 100 random vectors with random input gaps and random out_ready
        rand_ready = 1'b1;
        for (int k = 0; k < 100; k++) begin
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk); #1;
            end
            v = rnd128();
            send1(qr_fwd(v), v);
        end
        rand_ready = 1'b0;
        out_ready = 1'b1;
        drain1();
        repeat (4) @(posedge clk);
        #1;
        check("final_idle", in_ready, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
